// File: rtl/fft_mdc_pkg.sv
// Shared constants, stage-delay helper and FSM state type for the 32-point MDC FFT stage controllers.
package fft_mdc_pkg;

    localparam int N_FFT = 32;
    localparam int LOG2N = 5;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } mdc_state_t;

    // Delay-line depth of a stage: 8,4,2,1 for stages 0..3 and none for the last stage.
    function automatic int stage_delay(input int stage, input int n = N_FFT);
        return (stage >= LOG2N - 1) ? 0 : n / (4 << stage);
    endfunction

endpackage

// File: rtl/mdc_pair_counter.sv
// Pair index counter: increments on enable, synchronous load-to-zero, natural wrap at 2^W.
module mdc_pair_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    // clr together with en yields 1: the SOF pair takes index 0 and the next pair is 1.
    always_comb begin
        cnt_d = clr ? '0 : cnt_q;
        if (en) begin
            cnt_d = cnt_d + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mdc_stage_ctrl.sv
// Per-stage sequencer for one radix-2 MDC FFT stage: fill, run, stall, flush and datapath controls.
// The sticky misaligned-SOF flag is built only when MDC_CTRL_ERR_EN is defined.
module mdc_stage_ctrl
    import fft_mdc_pkg::*;
#(
    parameter int N     = N_FFT,
    parameter int STAGE = 0,
    parameter int TW_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_bypass,
    input  logic            in_valid,
    input  logic            in_sof,
    input  logic            in_last,
    input  logic            err_clr,
    output logic            butter_mode,
    output logic            dl_en,
    output logic            comm_sel,
    output logic [TW_W-1:0] tw_addr,
    output logic            out_valid,
    output logic            out_sof,
    output logic            busy,
    output logic            err_sof
);

    localparam int              D       = stage_delay(STAGE, N);
    localparam int              CBIT    = (D > 1) ? $clog2(D) : 0;
    localparam int              FW      = $clog2(N / 4 + 1);
    localparam logic [TW_W-1:0] TW_MASK = TW_W'((N / 2 >> STAGE) - 1);
    localparam logic [TW_W-1:0] D_IDX   = TW_W'(D);
    localparam logic [FW-1:0]   D_F     = FW'(D);

    mdc_state_t      state_q, state_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [TW_W-1:0] tw_addr_q, tw_addr_d;
    logic            dl_en_q, dl_en_d;
    logic            comm_sel_q, comm_sel_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sof_q, out_sof_d;
    logic            busy_q, busy_d;
    logic            butter_mode_q;

    logic [TW_W-1:0] cnt_q;
    logic [TW_W-1:0] idx;
    logic            cnt_en, cnt_clr, upd;

    mdc_pair_counter #(.W(TW_W)) u_pair_counter (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .cnt (cnt_q)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b0;
        idx         = cnt_q;
        upd         = 1'b0;
        dl_en_d     = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_sof) begin
                    cnt_en  = 1'b1;
                    cnt_clr = 1'b1;
                    idx     = '0;
                    upd     = 1'b1;
                    dl_en_d = 1'b1;
                    if (D == 0) begin
                        out_valid_d = 1'b1;
                        state_d     = in_last ? IDLE : RUN;
                    end else if (in_last) begin
                        fcnt_d  = D_F;
                        state_d = FLUSH;
                    end else begin
                        fcnt_d  = FW'(1);
                        state_d = (D == 1) ? RUN : FILL;
                    end
                end
            end
            FILL, RUN: begin
                if (in_valid) begin
                    cnt_en      = 1'b1;
                    cnt_clr     = in_sof;
                    idx         = in_sof ? '0 : cnt_q;
                    upd         = 1'b1;
                    dl_en_d     = 1'b1;
                    out_valid_d = (state_q == RUN);
                    if (in_last) begin
                        fcnt_d  = D_F;
                        state_d = (D == 0) ? IDLE : FLUSH;
                    end else if (state_q == FILL) begin
                        fcnt_d = fcnt_q + FW'(1);
                        if (fcnt_q + FW'(1) == D_F) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            FLUSH: begin
                // Drain the delay line; the index keeps advancing as if phantom pairs arrived.
                cnt_en      = 1'b1;
                upd         = 1'b1;
                dl_en_d     = 1'b1;
                out_valid_d = 1'b1;
                fcnt_d      = fcnt_q - FW'(1);
                if (fcnt_q == FW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tw_addr_d  = tw_addr_q;
        comm_sel_d = comm_sel_q;
        out_sof_d  = 1'b0;
        if (upd) begin
            tw_addr_d  = (idx & TW_MASK) << STAGE;
            comm_sel_d = (D > 0) ? idx[CBIT] : 1'b0;
            out_sof_d  = out_valid_d && (idx == D_IDX);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fcnt_q        <= '0;
            tw_addr_q     <= '0;
            dl_en_q       <= 1'b0;
            comm_sel_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            busy_q        <= 1'b0;
            butter_mode_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            tw_addr_q     <= tw_addr_d;
            dl_en_q       <= dl_en_d;
            comm_sel_q    <= comm_sel_d;
            out_valid_q   <= out_valid_d;
            out_sof_q     <= out_sof_d;
            busy_q        <= busy_d;
            butter_mode_q <= cfg_bypass;
        end
    end

`ifdef MDC_CTRL_ERR_EN
    logic err_q, err_d;
    logic err_set;

    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_comb begin
        err_set = in_valid && ((state_q == IDLE && !in_sof) ||
                               ((state_q == FILL || state_q == RUN) && in_sof && cnt_q != '0));
        err_d   = err_clr ? 1'b0 : err_q;
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sof = err_q;
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign err_sof        = 1'b0;
`endif

    assign butter_mode = butter_mode_q;
    assign dl_en       = dl_en_q;
    assign comm_sel    = comm_sel_q;
    assign tw_addr     = tw_addr_q;
    assign out_valid   = out_valid_q;
    assign out_sof     = out_sof_q;
    assign busy        = busy_q;

endmodule
